// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B, LSB first, one bit per clock.
// A full-subtractor cell is fed from the LSBs of two operand shift registers
// and a borrow flip-flop. The result is collected in a right-shifting register
// and published in parallel together with a one-cycle done pulse.
// Optional macro SERIAL_SUB_SIGNED_OVF_EN adds ovf_o, the two's-complement
// signed overflow flag of the completed subtraction.
// Handshake: start_i is a request sampled only while the FSM is IDLE, and
// there is no ready signal. A start seen in SHIFT or DONE is dropped. busy_o
// marks the SHIFT window. done_o is a one-cycle valid strobe for
// diff_o/borrow_o, which hold until the next completed operation.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  output logic             ovf_o,
`endif
  output logic             bit_o,
  output logic             bit_vld_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int RES_W = WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // state_q is the FSM state; bind checkers observe it directly
  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the WIDTH-1 bits already produced. The final bit is concatenated on
  // the last edge, so the register never needs a slot that is thrown away.
  logic [RES_W-1:0] res_sh;
  logic [CNT_W-1:0] cnt_q;
  logic             borrow_ff;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             done_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic             ovf_q;
`endif

  logic d_bit;
  logic bout;
  logic last_bit;

  // Full-subtractor cell on the current operand LSBs and the stored borrow
  always_comb begin
    d_bit    = a_sh[0] ^ b_sh[0] ^ borrow_ff;
    bout     = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & borrow_ff) | (b_sh[0] & borrow_ff);
    last_bit = (cnt_q == LAST_CNT);
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, serial shifting and result publication
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      cnt_q     <= '0;
      borrow_ff <= 1'b0;
      diff_q    <= '0;
      borrow_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            a_sh      <= a_i;
            b_sh      <= b_i;
            cnt_q     <= '0;
            borrow_ff <= 1'b0;
          end
        end
        SHIFT: begin
          a_sh      <= a_sh >> 1;
          b_sh      <= b_sh >> 1;
          res_sh    <= RES_W'({d_bit, res_sh} >> 1);
          borrow_ff <= bout;
          cnt_q     <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            // a_sh[0]/b_sh[0] are the operand MSBs on this final cycle
            diff_q   <= {d_bit, res_sh};
            borrow_q <= bout;
            done_q   <= 1'b1;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            ovf_q    <= (a_sh[0] ^ b_sh[0]) & (d_bit ^ a_sh[0]);
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy_o    = (state_q == SHIFT);
  assign bit_vld_o = (state_q == SHIFT);
  assign bit_o     = (state_q == SHIFT) & d_bit;
  assign done_o    = done_q;
  assign diff_o    = diff_q;
  assign borrow_o  = borrow_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  assign ovf_o     = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed plus random checks of serial_subtractor
// (WIDTH=8). A reference model based on plain A-B arithmetic fills the
// expected queues as each start is driven, and the monitor drains them.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         bit_s;
  logic         bit_vld;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;
  int n_exp_done = 0;

  // {ovf, borrow, diff} per accepted operation, and serial bits LSB first
  logic [W+1:0] exp_q[$];
  logic         exp_bit_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .a_i       (a),
    .b_i       (b),
    .busy_o    (busy),
    .done_o    (done),
    .diff_o    (diff),
    .borrow_o  (borrow),
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    .ovf_o     (ovf),
`endif
    .bit_o     (bit_s),
    .bit_vld_o (bit_vld)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb);
    logic [W:0] full;
    logic       v;
    full = {1'b0, ma} - {1'b0, mb};
    v    = (ma[W-1] ^ mb[W-1]) & (full[W-1] ^ ma[W-1]);
    return {v, full[W], full[W-1:0]};
  endfunction

  // Drive a start request for one cycle; returns at the first sample after the start edge
  task automatic launch(input logic [W-1:0] la, input logic [W-1:0] lb, input bit accept);
    logic [W+1:0] e;
    start = 1'b1;
    a     = la;
    b     = lb;
    if (accept) begin
      e = model(la, lb);
      exp_q.push_back(e);
      for (int i = 0; i < W; i++) exp_bit_q.push_back(e[i]);
      n_exp_done++;
    end
    @(negedge clk);
    start = 1'b0;
    a     = $urandom_range(0, 255);
    b     = $urandom_range(0, 255);
  endtask

  // Bounded wait for done; k counts samples after the start edge
  task automatic wait_done(input int k0, output int k_done, output int busy_cnt);
    k_done   = -1;
    busy_cnt = 0;
    for (int k = k0; k <= 30; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        k_done = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ra, input logic [W-1:0] rb);
    int kd;
    int bc;
    launch(ra, rb, 1'b1);
    wait_done(1, kd, bc);
    check({tag, "_done_latency"}, kd, W + 1);
    check({tag, "_busy_cycles"}, bc, W);
    @(negedge clk);
  endtask

  // Scoreboard monitor: drains serial bits and completed results
  always @(negedge clk) begin : monitor
    logic [W+1:0] e;
    logic         eb;
    if (bit_vld) begin
      if (exp_bit_q.size() == 0) begin
        check("spurious_bit_vld", bit_vld, 0);
      end else begin
        eb = exp_bit_q.pop_front();
        check("bit_o", bit_s, eb);
      end
    end
    if (done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check("spurious_done", done, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_diff", diff, e[W-1:0]);
        check("sb_borrow", borrow, e[W]);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        check("sb_ovf", ovf, e[W+1]);
`endif
      end
    end
  end

  // Directed sequence
  initial begin
    int kd;
    int bc;
    int d0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
    check("rst_bit", bit_s, 0);
    check("rst_bit_vld", bit_vld, 0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Basic subtraction with latency and pulse-width checks
    launch(8'h5A, 8'h23, 1'b1);
    wait_done(1, kd, bc);
    check("t1_done_latency", kd, W + 1);
    check("t1_busy_cycles", bc, W);
    check("t1_diff", diff, 8'h37);
    check("t1_borrow", borrow, 0);
    @(negedge clk);
    check("t1_done_one_cycle", done, 0);
    check("t1_diff_hold", diff, 8'h37);

    // Borrow out and equal operands
    run_op("t2a", 8'h10, 8'h20);
    check("t2a_diff", diff, 8'hF0);
    check("t2a_borrow", borrow, 1);
    run_op("t2b", 8'hFF, 8'hFF);
    check("t2b_diff", diff, 8'h00);
    check("t2b_borrow", borrow, 0);
    run_op("t2c", 8'h00, 8'h01);
    check("t2c_diff", diff, 8'hFF);
    check("t2c_borrow", borrow, 1);

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    run_op("t3a", 8'h80, 8'h01);
    check("t3a_ovf", ovf, 1);
    check("t3a_diff", diff, 8'h7F);
    run_op("t3b", 8'h05, 8'h03);
    check("t3b_ovf", ovf, 0);
`endif

    // Starts during SHIFT and DONE are ignored
    d0 = done_seen;
    launch(8'h09, 8'h04, 1'b1);
    repeat (2) @(negedge clk);
    launch(8'h00, 8'hFF, 1'b0);
    wait_done(4, kd, bc);
    check("t4_done_latency", kd, W + 1);
    check("t4_diff", diff, 8'h05);
    launch(8'h00, 8'hFF, 1'b0);
    repeat (12) @(negedge clk);
    check("t4_busy_after", busy, 0);
    check("t4_diff_hold", diff, 8'h05);
    check("t4_done_pulses", done_seen - d0, 1);

    // Reset mid-SHIFT aborts the operation
    d0 = done_seen;
    launch(8'h33, 8'h11, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_bit_q.delete();
    n_exp_done--;
    check("t5_busy_after_rst", busy, 0);
    check("t5_diff_after_rst", diff, 0);
    check("t5_bit_vld_after_rst", bit_vld, 0);
    repeat (12) @(negedge clk);
    check("t5_no_done", done_seen - d0, 0);
    run_op("t5b", 8'h02, 8'h03);
    check("t5b_diff", diff, 8'hFF);
    check("t5b_borrow", borrow, 1);

    // Back-to-back: start on the first IDLE cycle after DONE
    launch(8'h44, 8'h04, 1'b1);
    wait_done(1, kd, bc);
    check("t6a_diff", diff, 8'h40);
    @(negedge clk);
    launch(8'h01, 8'h02, 1'b1);
    check("t6b_accepted", busy, 1);
    repeat (3) @(negedge clk);
    check("t6b_diff_hold", diff, 8'h40);
    wait_done(4, kd, bc);
    check("t6b_done_latency", kd, W + 1);
    check("t6b_diff", diff, 8'hFF);
    check("t6b_borrow", borrow, 1);
    @(negedge clk);

    // Random operands through the scoreboard
    for (int i = 0; i < 6; i++) begin
      run_op("rnd", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("exp_bit_q_drained", exp_bit_q.size(), 0);
    check("done_count", done_seen, n_exp_done);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
